// File: rtl/timer_cfg_sequencer_if.sv
// APB bus between the timer configuration sequencer (master) and the timer register slave.
interface timer_cfg_sequencer_if;
  logic [31:0] m_paddr;
  logic        m_psel;
  logic        m_penable;
  logic        m_pwrite;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic [31:0] m_prdata;
  logic        m_pready;
  logic        m_pslverr;

  modport master (
    output m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
    input  m_prdata, m_pready, m_pslverr
  );

  modport slave (
    input  m_paddr, m_psel, m_penable, m_pwrite, m_pwdata, m_pstrb,
    output m_prdata, m_pready, m_pslverr
  );
endinterface

// File: rtl/timer_cfg_sequencer.sv
// APB master that disables, programs and re-arms the timer IP base timer on a start pulse,
// optionally polling STATUS.ld until the load completes.
module timer_cfg_sequencer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] OFF_CONFIG = 32'h00,
  parameter logic [31:0] OFF_PRESC  = 32'h04,
  parameter logic [31:0] OFF_PERIOD = 32'h08,
  parameter logic [31:0] OFF_LOAD   = 32'h0C,
  parameter logic [31:0] OFF_STATUS = 32'h14,
  parameter int unsigned POLL_MAX   = 16,
  parameter int unsigned WAIT_MAX   = 255
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        start,
  input  logic        abort,
  input  logic        cfg_ar,
  input  logic        cfg_dir,
  input  logic        cfg_ud,
  input  logic [31:0] cfg_div,
  input  logic [31:0] cfg_per,
  input  logic [31:0] cfg_load,
  input  logic        wait_ld,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [3:0]  last_status,
  timer_cfg_sequencer_if.master apb
);

  localparam int unsigned    PW          = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0]  POLL_LIM    = PW'(POLL_MAX);
  localparam logic [7:0]     WAIT_LAST   = 8'(WAIT_MAX - 32'd1);
  localparam logic [2:0]     STEP_CFG_EN = 3'd4;
  localparam logic [2:0]     STEP_STATUS = 3'd5;
  localparam logic [1:0]     ERR_NONE    = 2'b00;
  localparam logic [1:0]     ERR_SLV     = 2'b01;
  localparam logic [1:0]     ERR_TMO     = 2'b10;
  localparam logic [1:0]     ERR_POLL    = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state;
  logic [2:0]    step;
  logic [7:0]    wait_cnt;
  logic [PW-1:0] poll_cnt;
  logic [31:0]   div_q;
  logic [31:0]   per_q;
  logic [31:0]   load_q;
  logic [2:0]    mode_q;
  logic          wait_ld_q;

  logic [2:0]    issue_step_c;
  logic [31:0]   issue_addr_c;
  logic [31:0]   issue_data_c;
  logic          issue_wr_c;
  logic          issue_c;
  logic          acc_setup_c;
  logic          acc_done_c;
  logic          capture_c;
  logic [1:0]    acc_err_c;
  logic [PW-1:0] poll_inc_c;
  logic          unused_prdata_c;

  function automatic logic [31:0] xfer_addr(input logic [2:0] s);
    logic [31:0] off;
    case (s)
      3'd0:    off = OFF_CONFIG;
      3'd1:    off = OFF_PRESC;
      3'd2:    off = OFF_PERIOD;
      3'd3:    off = OFF_LOAD;
      3'd4:    off = OFF_CONFIG;
      default: off = OFF_STATUS;
    endcase
    return BASE_ADDR + off;
  endfunction

  function automatic logic [31:0] xfer_data(input logic [2:0] s, input logic [31:0] div,
                                            input logic [31:0] per, input logic [31:0] load,
                                            input logic [2:0] mode);
    case (s)
      3'd1:    return div;
      3'd2:    return per;
      3'd3:    return load;
      3'd4:    return {28'd0, mode, 1'b1};
      default: return 32'd0;
    endcase
  endfunction

  // Next transfer to launch: step 0 from IDLE, otherwise advance (STATUS re-reads stay on step 5).
  always_comb begin
    issue_step_c = 3'd0;
    if (state != IDLE) begin
      issue_step_c = (step == STEP_STATUS) ? STEP_STATUS : step + 3'd1;
    end
    issue_addr_c = xfer_addr(issue_step_c);
    issue_data_c = xfer_data(issue_step_c, div_q, per_q, load_q, mode_q);
    issue_wr_c   = (issue_step_c != STEP_STATUS);
  end

  assign poll_inc_c      = (poll_cnt == POLL_LIM) ? poll_cnt : poll_cnt + PW'(1);
  assign unused_prdata_c = ^apb.m_prdata[31:4];

  // Outcome of the ACCESS phase; slave error outranks abort.
  always_comb begin
    acc_setup_c = 1'b0;
    acc_done_c  = 1'b0;
    capture_c   = 1'b0;
    acc_err_c   = ERR_NONE;
    if (state == ACCESS) begin
      if (apb.m_pready) begin
        if (apb.m_pslverr) begin
          acc_done_c = 1'b1;
          acc_err_c  = ERR_SLV;
        end else if (abort) begin
          acc_done_c = 1'b1;
        end else if (step < STEP_CFG_EN) begin
          acc_setup_c = 1'b1;
        end else if (step == STEP_CFG_EN) begin
          acc_setup_c = wait_ld_q;
          acc_done_c  = !wait_ld_q;
        end else begin
          capture_c = 1'b1;
          if (apb.m_prdata[3]) begin
            acc_done_c = 1'b1;
          end else if (poll_inc_c == POLL_LIM) begin
            acc_done_c = 1'b1;
            acc_err_c  = ERR_POLL;
          end else begin
            acc_setup_c = 1'b1;
          end
        end
      end else if (wait_cnt == WAIT_LAST) begin
        acc_done_c = 1'b1;
        acc_err_c  = ERR_TMO;
      end
    end
  end

  assign issue_c = ((state == IDLE) && start) || acc_setup_c;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state         <= IDLE;
      step          <= 3'd0;
      wait_cnt      <= 8'd0;
      poll_cnt      <= '0;
      div_q         <= 32'd0;
      per_q         <= 32'd0;
      load_q        <= 32'd0;
      mode_q        <= 3'd0;
      wait_ld_q     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      last_status   <= 4'd0;
      apb.m_paddr   <= 32'd0;
      apb.m_psel    <= 1'b0;
      apb.m_penable <= 1'b0;
      apb.m_pwrite  <= 1'b0;
      apb.m_pwdata  <= 32'd0;
      apb.m_pstrb   <= 4'd0;
    end else begin
      done <= 1'b0;
      if (issue_c) begin
        state         <= SETUP;
        step          <= issue_step_c;
        apb.m_psel    <= 1'b1;
        apb.m_penable <= 1'b0;
        apb.m_paddr   <= issue_addr_c;
        apb.m_pwdata  <= issue_data_c;
        apb.m_pwrite  <= issue_wr_c;
        apb.m_pstrb   <= issue_wr_c ? 4'hF : 4'h0;
      end
      case (state)
        IDLE: begin
          if (start) begin
            div_q     <= cfg_div;
            per_q     <= cfg_per;
            load_q    <= cfg_load;
            mode_q    <= {cfg_ud, cfg_dir, cfg_ar};
            wait_ld_q <= wait_ld;
            poll_cnt  <= '0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            busy      <= 1'b1;
          end
        end
        SETUP: begin
          apb.m_penable <= 1'b1;
          wait_cnt      <= 8'd0;
          state         <= ACCESS;
        end
        ACCESS: begin
          if (capture_c) begin
            last_status <= apb.m_prdata[3:0];
            poll_cnt    <= poll_inc_c;
          end
          if (acc_done_c) begin
            state         <= DONE;
            busy          <= 1'b0;
            done          <= 1'b1;
            apb.m_psel    <= 1'b0;
            apb.m_penable <= 1'b0;
            if (acc_err_c != ERR_NONE) begin
              error    <= 1'b1;
              err_code <= acc_err_c;
            end
          end else if (!apb.m_pready) begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cfg_sequencer.sv
// Scoreboard bench for timer_cfg_sequencer: expected APB transfers and sequence results are
// queued by the stimulus and checked by a monitor as the DUT presents them.
module tb_timer_cfg_sequencer;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        start, abort, cfg_ar, cfg_dir, cfg_ud, wait_ld;
  logic [31:0] cfg_div, cfg_per, cfg_load;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  last_status;

  always #5 PCLK = ~PCLK;

  timer_cfg_sequencer_if bus();

  timer_cfg_sequencer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .abort(abort),
    .cfg_ar(cfg_ar), .cfg_dir(cfg_dir), .cfg_ud(cfg_ud),
    .cfg_div(cfg_div), .cfg_per(cfg_per), .cfg_load(cfg_load), .wait_ld(wait_ld),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .last_status(last_status), .apb(bus.master)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [3:0]  strb;
  } xfer_t;

  typedef struct {
    logic       err;
    logic [1:0] code;
    logic       chk_ls;
    logic [3:0] ls;
    int         lat;
  } res_t;

  xfer_t      exp_q[$];
  res_t       res_q[$];
  logic [3:0] status_q[$];
  int tests = 0, fails = 0;
  int cyc = 0, e0 = 0, done_cnt = 0, acc_neg = 0, acc_cyc = 0;
  int wait_states = 0;
  logic hold_low = 1'b0, err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [3:0]  dflt_status = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge PCLK) cyc++;

  // Slave model: responds after wait_states ACCESS cycles, STATUS reads pop status_q.
  always @(posedge PCLK) begin
    #1;
    if (bus.m_psel && bus.m_penable) begin
      if (!hold_low && acc_cyc >= wait_states) begin
        bus.m_pready  = 1'b1;
        bus.m_pslverr = err_en && (bus.m_paddr == err_addr);
        if (!bus.m_pwrite) begin
          if (status_q.size() > 0) bus.m_prdata = {28'hABC_DEF0, status_q.pop_front()};
          else bus.m_prdata = {28'hABC_DEF0, dflt_status};
        end
      end else begin
        bus.m_pready  = 1'b0;
        bus.m_pslverr = 1'b0;
      end
      acc_cyc++;
    end else begin
      bus.m_pready  = 1'b0;
      bus.m_pslverr = 1'b0;
      acc_cyc = 0;
    end
  end

  // Monitor: checks every completed transfer and every done pulse against the queues.
  xfer_t mx;
  res_t  mr;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      if (bus.m_psel && bus.m_penable) acc_neg++;
      if (bus.m_psel && bus.m_penable && bus.m_pready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_xfer: addr 'h%0h issued, nothing expected", bus.m_paddr);
        end else begin
          mx = exp_q.pop_front();
          chk("paddr", bus.m_paddr, mx.addr);
          chk("pwrite", 32'(bus.m_pwrite), 32'(mx.wr));
          chk("pstrb", 32'(bus.m_pstrb), 32'(mx.strb));
          if (mx.wr) chk("pwdata", bus.m_pwdata, mx.data);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_exclusive", 32'(busy), 32'd0);
        if (res_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done pulse with no sequence expected");
        end else begin
          mr = res_q.pop_front();
          chk("error", 32'(error), 32'(mr.err));
          chk("err_code", 32'(err_code), 32'(mr.code));
          if (mr.chk_ls) chk("last_status", 32'(last_status), 32'(mr.ls));
          if (mr.lat >= 0) chk("done_latency", 32'(cyc - e0), 32'(mr.lat));
        end
      end
    end
  end

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{addr: a, wr: 1'b1, data: d, strb: 4'hF});
  endtask

  task automatic push_r();
    exp_q.push_back('{addr: 32'h14, wr: 1'b0, data: 32'h0, strb: 4'h0});
  endtask

  task automatic push_res(input logic e, input logic [1:0] c, input logic cl,
                          input logic [3:0] l, input int lat);
    res_q.push_back('{err: e, code: c, chk_ls: cl, ls: l, lat: lat});
  endtask

  task automatic set_cfg(input logic [31:0] d, input logic [31:0] p, input logic [31:0] l,
                         input logic ar, input logic dr, input logic ud, input logic wl);
    cfg_div = d; cfg_per = p; cfg_load = l;
    cfg_ar = ar; cfg_dir = dr; cfg_ud = ud; wait_ld = wl;
  endtask

  task automatic push_writes(input logic [31:0] d, input logic [31:0] p, input logic [31:0] l,
                             input logic [3:0] cfg);
    push_w(32'h00, 32'h0);
    push_w(32'h04, d);
    push_w(32'h08, p);
    push_w(32'h0C, l);
    push_w(32'h00, {28'h0, cfg});
  endtask

  task automatic do_start();
    @(negedge PCLK);
    start = 1'b1;
    @(posedge PCLK);
    #1;
    e0 = cyc;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("error_cleared", 32'(error), 32'd0);
    chk("err_code_cleared", 32'(err_code), 32'd0);
  endtask

  task automatic wait_done(input int n0, input int maxc);
    int k;
    k = 0;
    while (done_cnt == n0 && k < maxc) begin
      @(posedge PCLK);
      k++;
    end
    tests++;
    if (done_cnt == n0) begin
      fails++;
      $display("FAIL done_timeout: no done within %0d cycles", maxc);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    start = 1'b0; abort = 1'b0;
    set_cfg(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.m_pready = 1'b0; bus.m_pslverr = 1'b0; bus.m_prdata = 32'h0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_psel", 32'(bus.m_psel), 32'd0);
    chk("rst_penable", 32'(bus.m_penable), 32'd0);
    chk("rst_paddr", bus.m_paddr, 32'd0);
    chk("rst_pwdata", bus.m_pwdata, 32'd0);
    chk("rst_pwrite_pstrb", {27'd0, bus.m_pwrite, bus.m_pstrb}, 32'd0);
    chk("rst_flags", {27'd0, busy, done, error, err_code}, 32'd0);
    chk("rst_last_status", 32'(last_status), 32'd0);
    PRESETn = 1'b1;

    // Basic programming, zero-wait slave; a start pulse mid-sequence must be ignored.
    set_cfg(32'd4, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    push_writes(32'd4, 32'd100, 32'd7, 4'hB);
    push_res(1'b0, 2'b00, 1'b0, 4'h0, 10);
    n = done_cnt;
    do_start();
    repeat (3) @(negedge PCLK);
    start = 1'b1; cfg_div = 32'd99;
    @(negedge PCLK);
    start = 1'b0;
    wait_done(n, 40);
    repeat (4) @(posedge PCLK);
    #1 chk("idle_after_busy_start", 32'(busy), 32'd0);

    // Poll: ld clear twice then set.
    set_cfg(32'd4, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, 1'b1);
    status_q = '{4'h0, 4'h0, 4'h8};
    push_writes(32'd4, 32'd100, 32'd7, 4'hB);
    repeat (3) push_r();
    push_res(1'b0, 2'b00, 1'b1, 4'h8, 16);
    n = done_cnt;
    do_start();
    wait_done(n, 40);

    // Poll timeout: ld never sets, 16 reads.
    dflt_status = 4'h4;
    push_writes(32'd4, 32'd100, 32'd7, 4'hB);
    repeat (16) push_r();
    push_res(1'b1, 2'b11, 1'b1, 4'h4, 42);
    n = done_cnt;
    do_start();
    wait_done(n, 80);

    // PSLVERR on the PERIOD write, one wait state per transfer.
    set_cfg(32'd4, 32'd100, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_states = 1; err_en = 1'b1; err_addr = 32'h08;
    push_w(32'h00, 32'h0);
    push_w(32'h04, 32'd4);
    push_w(32'h08, 32'd100);
    push_res(1'b1, 2'b01, 1'b0, 4'h0, 9);
    n = done_cnt;
    do_start();
    wait_done(n, 40);
    wait_states = 0; err_en = 1'b0;

    // PREADY timeout.
    hold_low = 1'b1;
    push_res(1'b1, 2'b10, 1'b0, 4'h0, 256);
    n = done_cnt;
    acc_neg = 0;
    do_start();
    wait_done(n, 400);
    chk("timeout_access_cycles", 32'(acc_neg), 32'd255);
    hold_low = 1'b0;

    // Abort during the PRESC access; this start also clears the previous error.
    push_w(32'h00, 32'h0);
    push_w(32'h04, 32'd4);
    push_res(1'b0, 2'b00, 1'b0, 4'h0, 4);
    n = done_cnt;
    do_start();
    repeat (3) @(posedge PCLK);
    #1 abort = 1'b1;
    wait_done(n, 20);
    abort = 1'b0;

    // PSLVERR and abort on the same completion: error wins.
    abort = 1'b1; err_en = 1'b1; err_addr = 32'h00;
    push_w(32'h00, 32'h0);
    push_res(1'b1, 2'b01, 1'b0, 4'h0, 2);
    n = done_cnt;
    do_start();
    wait_done(n, 20);
    abort = 1'b0; err_en = 1'b0;

    // Reset in the middle of the PERIOD access: no resumption, no done.
    push_w(32'h00, 32'h0);
    push_w(32'h04, 32'd4);
    n = done_cnt;
    do_start();
    repeat (5) @(posedge PCLK);
    #1 chk("psel_before_reset", {30'd0, bus.m_psel, bus.m_penable}, 32'd3);
    #2 PRESETn = 1'b0;
    #1;
    chk("reset_psel", 32'(bus.m_psel), 32'd0);
    chk("reset_paddr", bus.m_paddr, 32'd0);
    chk("reset_pwdata", bus.m_pwdata, 32'd0);
    chk("reset_flags", {26'd0, busy, done, error, err_code, bus.m_penable}, 32'd0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (20) @(posedge PCLK);
    #1;
    chk("no_resume_done", 32'(done_cnt), 32'(n));
    chk("no_resume_queue", 32'(exp_q.size()), 32'd0);
    chk("no_resume_psel", {30'd0, bus.m_psel, busy}, 32'd0);

    // Full sequence after reset with two wait states and a poll.
    set_cfg(32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_states = 2;
    status_q = '{4'h8};
    push_writes(32'hDEAD_BEEF, 32'h0, 32'hFFFF_FFFF, 4'h5);
    push_r();
    push_res(1'b0, 2'b00, 1'b1, 4'h8, 24);
    n = done_cnt;
    do_start();
    wait_done(n, 60);

    repeat (3) @(posedge PCLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
